// File: rtl/sc_player_pkg.sv
// Shared encodings for the lane-based player position logic.
package sc_player_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACTIVE = 2'b01,
      CRASH  = 2'b10
   } state_t;

   localparam logic [1:0] SEL_HOLD  = 2'b00;
   localparam logic [1:0] SEL_LEFT  = 2'b01;
   localparam logic [1:0] SEL_RIGHT = 2'b10;

   // True when the joystick code requests a move (01 or 10).
   function automatic logic is_dir(input logic [1:0] sel);
      return (sel == SEL_LEFT) || (sel == SEL_RIGHT);
   endfunction

endpackage

// File: rtl/sc_player_repeat_gen.sv
// Hold-to-repeat generator: turns ticked joystick selections into move strobes.
// A new direction moves at once; a held direction repeats every REPEAT_TICKS ticks.
module sc_player_repeat_gen
   import sc_player_pkg::*;
#(
   parameter int REPEAT_TICKS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic [1:0] sel,
   input  logic       clear,
   output logic       move,
   output logic       move_left
);

   localparam int CW = $clog2(REPEAT_TICKS) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(REPEAT_TICKS - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [1:0]    last_sel_r;
   logic [CW-1:0] cnt_r;

   // Decide whether this tick produces a move and in which direction.
   always_comb begin
      move      = 1'b0;
      move_left = (sel == SEL_LEFT);
      if (tick && is_dir(sel)) begin
         if (sel != last_sel_r) begin
            move = 1'b1;
         end else if (cnt_r == CNT_LAST) begin
            move = 1'b1;
         end else begin
            move = 1'b0;
         end
      end else begin
         move = 1'b0;
      end
   end

   // Remember the last ticked selection and count ticks since the last move.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         last_sel_r <= SEL_HOLD;
         cnt_r      <= '0;
      end else if (tick) begin
         last_sel_r <= sel;
         if (is_dir(sel) && !move) begin
            cnt_r <= cnt_r + CNT_ONE;
         end else begin
            cnt_r <= '0;
         end
      end else begin
         last_sel_r <= last_sel_r;
         cnt_r      <= cnt_r;
      end
   end

endmodule

// File: rtl/sc_regshifter_player_lane.sv
// Player lane register: spawn, tick-gated saturating movement with auto-repeat,
// and a crash/respawn sequence that blinks the one-hot position.
module sc_regshifter_player_lane
   import sc_player_pkg::*;
#(
   parameter int DATAWIDTH    = 8,
   parameter int LANE_MIN     = 4,
   parameter int LANE_MAX     = 7,
   parameter int SPAWN_LANE   = 4,
   parameter int REPEAT_TICKS = 4,
   parameter int CRASH_TICKS  = 8
) (
   input  logic                         SC_PlayerLane_CLOCK_50,
   input  logic                         SC_PlayerLane_RESET_InHigh,
   input  logic                         SC_PlayerLane_tick_In,
   input  logic                         SC_PlayerLane_spawn_InLow,
   input  logic [1:0]                   SC_PlayerLane_shiftselection_In,
   input  logic                         SC_PlayerLane_crash_In,
   output logic [DATAWIDTH-1:0]         SC_PlayerLane_data_OutBUS,
   output logic [$clog2(DATAWIDTH)-1:0] SC_PlayerLane_lane_Out,
   output logic [1:0]                   SC_PlayerLane_state_Out,
   output logic                         SC_PlayerLane_atLeft_Out,
   output logic                         SC_PlayerLane_atRight_Out,
   output logic                         SC_PlayerLane_crash_Out
);

   localparam int LW  = $clog2(DATAWIDTH);
   localparam int CCW = $clog2(CRASH_TICKS) + 1;
   localparam logic [LW-1:0]        LANE_MIN_L   = LW'(LANE_MIN);
   localparam logic [LW-1:0]        LANE_MAX_L   = LW'(LANE_MAX);
   localparam logic [LW-1:0]        LANE_SPAWN_L = LW'(SPAWN_LANE);
   localparam logic [LW-1:0]        LANE_ONE     = LW'(1);
   localparam logic [CCW-1:0]       CCNT_LAST    = CCW'(CRASH_TICKS - 1);
   localparam logic [CCW-1:0]       CCNT_ONE     = CCW'(1);
   localparam logic [DATAWIDTH-1:0] BUS_ONE      = DATAWIDTH'(1);

   state_t         state_r, state_n;
   logic [LW-1:0]  lane_r, lane_n;
   logic [CCW-1:0] ccnt_r, ccnt_n;
   logic           blink_r, blink_n;
   logic           clear_s;
   logic           move_tick_s;
   logic           move_s;
   logic           move_left_s;
   logic [DATAWIDTH-1:0] bus_n;

   // Only a plain ACTIVE tick (no spawn, no crash) may advance the repeat logic.
   assign move_tick_s = SC_PlayerLane_tick_In && (state_r == ACTIVE) &&
                        SC_PlayerLane_spawn_InLow && !SC_PlayerLane_crash_In;

   sc_player_repeat_gen #(
      .REPEAT_TICKS(REPEAT_TICKS)
   ) u_repeat (
      .clk       (SC_PlayerLane_CLOCK_50),
      .reset     (SC_PlayerLane_RESET_InHigh),
      .tick      (move_tick_s),
      .sel       (SC_PlayerLane_shiftselection_In),
      .clear     (clear_s),
      .move      (move_s),
      .move_left (move_left_s)
   );

   // Next-state logic with priority spawn > crash > tick-move.
   always_comb begin
      state_n = state_r;
      lane_n  = lane_r;
      ccnt_n  = ccnt_r;
      blink_n = blink_r;
      clear_s = 1'b0;
      if (!SC_PlayerLane_spawn_InLow) begin
         state_n = ACTIVE;
         lane_n  = LANE_SPAWN_L;
         ccnt_n  = '0;
         blink_n = 1'b0;
         clear_s = 1'b1;
      end else begin
         case (state_r)
            IDLE: begin
               state_n = IDLE;
            end
            ACTIVE: begin
               if (SC_PlayerLane_crash_In) begin
                  state_n = CRASH;
                  ccnt_n  = '0;
                  blink_n = 1'b0;
               end else if (move_s) begin
                  if (move_left_s) begin
                     if (lane_r < LANE_MAX_L) begin
                        lane_n = lane_r + LANE_ONE;
                     end else begin
                        lane_n = lane_r;
                     end
                  end else begin
                     if (lane_r > LANE_MIN_L) begin
                        lane_n = lane_r - LANE_ONE;
                     end else begin
                        lane_n = lane_r;
                     end
                  end
               end else begin
                  lane_n = lane_r;
               end
            end
            CRASH: begin
               if (SC_PlayerLane_tick_In) begin
                  if (ccnt_r == CCNT_LAST) begin
                     state_n = ACTIVE;
                     lane_n  = LANE_SPAWN_L;
                     ccnt_n  = '0;
                     blink_n = 1'b0;
                     clear_s = 1'b1;
                  end else begin
                     blink_n = ~blink_r;
                     ccnt_n  = ccnt_r + CCNT_ONE;
                  end
               end else begin
                  ccnt_n = ccnt_r;
               end
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

   // Decode the next visible bus: shown when ACTIVE or during the lit half of a blink.
   always_comb begin
      bus_n = '0;
      if ((state_n == ACTIVE) || ((state_n == CRASH) && blink_n)) begin
         bus_n = BUS_ONE << lane_n;
      end else begin
         bus_n = '0;
      end
   end

   // State registers and registered outputs.
   always_ff @(posedge SC_PlayerLane_CLOCK_50) begin
      if (SC_PlayerLane_RESET_InHigh) begin
         state_r                   <= IDLE;
         lane_r                    <= '0;
         ccnt_r                    <= '0;
         blink_r                   <= 1'b0;
         SC_PlayerLane_data_OutBUS <= '0;
         SC_PlayerLane_atLeft_Out  <= 1'b0;
         SC_PlayerLane_atRight_Out <= 1'b0;
         SC_PlayerLane_crash_Out   <= 1'b0;
      end else begin
         state_r                   <= state_n;
         lane_r                    <= lane_n;
         ccnt_r                    <= ccnt_n;
         blink_r                   <= blink_n;
         SC_PlayerLane_data_OutBUS <= bus_n;
         SC_PlayerLane_atLeft_Out  <= (state_n == ACTIVE) && (lane_n == LANE_MAX_L);
         SC_PlayerLane_atRight_Out <= (state_n == ACTIVE) && (lane_n == LANE_MIN_L);
         SC_PlayerLane_crash_Out   <= (state_n == CRASH);
      end
   end

   assign SC_PlayerLane_lane_Out  = lane_r;
   assign SC_PlayerLane_state_Out = state_r;

endmodule

// File: tb/tb_sc_regshifter_player_lane.sv
// Self-checking bench: two parameterisations driven by shared stimulus and
// compared against a tick-counting behavioural model.
module tb_sc_regshifter_player_lane;

   logic       clk = 1'b0;
   logic       rst, tick, spawn_n, crash;
   logic [1:0] sel;

   logic [7:0]  bus_a;  logic [2:0] lane_a; logic [1:0] st_a; logic atl_a, atr_a, cr_a;
   logic [15:0] bus_b;  logic [3:0] lane_b; logic [1:0] st_b; logic atl_b, atr_b, cr_b;
   logic [15:0] vec_a;
   logic [24:0] vec_b;

   int checks = 0;
   int errors = 0;

   // model parameters: index 0 = default set, index 1 = wide set
   int p_lmin[2]  = '{4, 2};
   int p_lmax[2]  = '{7, 13};
   int p_spawn[2] = '{4, 8};
   int p_rep[2]   = '{4, 1};
   int p_crt[2]   = '{8, 8};
   // model state: st 0/1/2, lane, held selection, consecutive held ticks, ticks since crash
   int m_st[2], m_lane[2], m_held[2], m_k[2], m_ct[2];

   always #5 clk = ~clk;

   sc_regshifter_player_lane dut_a (
      .SC_PlayerLane_CLOCK_50(clk), .SC_PlayerLane_RESET_InHigh(rst),
      .SC_PlayerLane_tick_In(tick), .SC_PlayerLane_spawn_InLow(spawn_n),
      .SC_PlayerLane_shiftselection_In(sel), .SC_PlayerLane_crash_In(crash),
      .SC_PlayerLane_data_OutBUS(bus_a), .SC_PlayerLane_lane_Out(lane_a),
      .SC_PlayerLane_state_Out(st_a), .SC_PlayerLane_atLeft_Out(atl_a),
      .SC_PlayerLane_atRight_Out(atr_a), .SC_PlayerLane_crash_Out(cr_a));

   sc_regshifter_player_lane #(
      .DATAWIDTH(16), .LANE_MIN(2), .LANE_MAX(13), .SPAWN_LANE(8),
      .REPEAT_TICKS(1), .CRASH_TICKS(8)
   ) dut_b (
      .SC_PlayerLane_CLOCK_50(clk), .SC_PlayerLane_RESET_InHigh(rst),
      .SC_PlayerLane_tick_In(tick), .SC_PlayerLane_spawn_InLow(spawn_n),
      .SC_PlayerLane_shiftselection_In(sel), .SC_PlayerLane_crash_In(crash),
      .SC_PlayerLane_data_OutBUS(bus_b), .SC_PlayerLane_lane_Out(lane_b),
      .SC_PlayerLane_state_Out(st_b), .SC_PlayerLane_atLeft_Out(atl_b),
      .SC_PlayerLane_atRight_Out(atr_b), .SC_PlayerLane_crash_Out(cr_b));

   assign vec_a = {bus_a, lane_a, st_a, atl_a, atr_a, cr_a};
   assign vec_b = {bus_b, lane_b, st_b, atl_b, atr_b, cr_b};

   task automatic model_step(input int i);
      if (rst) begin
         m_st[i] = 0; m_lane[i] = 0; m_held[i] = 0; m_k[i] = 0; m_ct[i] = 0;
      end else if (!spawn_n) begin
         m_st[i] = 1; m_lane[i] = p_spawn[i]; m_held[i] = 0; m_k[i] = 0; m_ct[i] = 0;
      end else if (m_st[i] == 1) begin
         if (crash) begin
            m_st[i] = 2; m_ct[i] = 0;
         end else if (tick) begin
            if (sel == 2'b01 || sel == 2'b10) begin
               m_k[i] = (int'(sel) == m_held[i]) ? m_k[i] + 1 : 1;
               if ((m_k[i] - 1) % p_rep[i] == 0) begin
                  if (sel == 2'b01) m_lane[i] = (m_lane[i] + 1 > p_lmax[i]) ? p_lmax[i] : m_lane[i] + 1;
                  else              m_lane[i] = (m_lane[i] - 1 < p_lmin[i]) ? p_lmin[i] : m_lane[i] - 1;
               end
            end else begin
               m_k[i] = 0;
            end
            m_held[i] = int'(sel);
         end
      end else if (m_st[i] == 2 && tick) begin
         m_ct[i] = m_ct[i] + 1;
         if (m_ct[i] == p_crt[i]) begin
            m_st[i] = 1; m_lane[i] = p_spawn[i]; m_held[i] = 0; m_k[i] = 0; m_ct[i] = 0;
         end
      end
   endtask

   function automatic logic [15:0] exp_a();
      logic [7:0] b;
      b = 8'h00;
      if (m_st[0] == 1 || (m_st[0] == 2 && m_ct[0] % 2 == 1)) b = 8'h01 << m_lane[0];
      return {b, 3'(m_lane[0]), 2'(m_st[0]), m_st[0] == 1 && m_lane[0] == p_lmax[0],
              m_st[0] == 1 && m_lane[0] == p_lmin[0], m_st[0] == 2};
   endfunction

   function automatic logic [24:0] exp_b();
      logic [15:0] b;
      b = 16'h0000;
      if (m_st[1] == 1 || (m_st[1] == 2 && m_ct[1] % 2 == 1)) b = 16'h0001 << m_lane[1];
      return {b, 4'(m_lane[1]), 2'(m_st[1]), m_st[1] == 1 && m_lane[1] == p_lmax[1],
              m_st[1] == 1 && m_lane[1] == p_lmin[1], m_st[1] == 2};
   endfunction

   // advance model and both DUTs one clock, then settle before sampling
   task automatic step();
      model_step(0);
      model_step(1);
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rst = 1'b0; tick = 1'b0; spawn_n = 1'b1; crash = 1'b0; sel = 2'b00;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick = 1'($urandom); sel = 2'($urandom); crash = 1'($urandom); spawn_n = 1'($urandom);
         step();
         if (vec_a !== 16'h0000) begin errors++; $display("FAIL reset_a got %h exp 0000", vec_a); end
         checks++;
         if (vec_b !== exp_b()) begin errors++; $display("FAIL reset_b got %h exp %h", vec_b, exp_b()); end
         checks++;
      end
      idle_inputs();
      for (int c = 0; c < 6; c++) begin
         tick = 1'($urandom); sel = 2'($urandom); crash = 1'($urandom);
         step();
         if (st_a !== 2'b00 || bus_a !== 8'h00) begin
            errors++; $display("FAIL idle_a got st %b bus %h exp st 00 bus 00", st_a, bus_a);
         end
         checks++;
         if (vec_b !== exp_b()) begin errors++; $display("FAIL idle_b got %h exp %h", vec_b, exp_b()); end
         checks++;
      end
   endtask

   task automatic test_spawn();
      idle_inputs();
      spawn_n = 1'b0;
      step();
      spawn_n = 1'b1;
      if (st_a !== 2'b01 || bus_a !== 8'h10 || atr_a !== 1'b1 || lane_a !== 3'd4) begin
         errors++; $display("FAIL spawn_a got st %b bus %h atR %b exp st 01 bus 10 atR 1", st_a, bus_a, atr_a);
      end
      checks++;
      if (bus_b !== 16'h0100 || vec_b !== exp_b()) begin
         errors++; $display("FAIL spawn_b got %h exp %h", vec_b, exp_b());
      end
      checks++;
   endtask

   task automatic test_hold_left();
      logic [7:0] want;
      idle_inputs();
      sel = 2'b01;
      for (int t = 1; t <= 13; t++) begin
         tick = 1'b1; step();
         want = (t >= 9) ? 8'h80 : (t >= 5) ? 8'h40 : 8'h20;
         if (bus_a !== want || vec_a !== exp_a()) begin
            errors++; $display("FAIL hold_left tick %0d got bus %h vec %h exp bus %h", t, bus_a, vec_a, want);
         end
         checks++;
         if (vec_b !== exp_b()) begin errors++; $display("FAIL hold_left_b got %h exp %h", vec_b, exp_b()); end
         checks++;
         tick = 1'b0; step();
      end
      if (atl_a !== 1'b1) begin errors++; $display("FAIL hold_left_atleft got %b exp 1", atl_a); end
      checks++;
   endtask

   task automatic test_reverse();
      logic [7:0] want_tab [3] = '{8'h10, 8'h10, 8'h20};
      logic [1:0] sel_tab  [3] = '{2'b10, 2'b10, 2'b01};
      idle_inputs();
      spawn_n = 1'b0; step(); spawn_n = 1'b1;
      sel = 2'b01; tick = 1'b1; step(); tick = 1'b0; step();
      if (lane_a !== 3'd5) begin errors++; $display("FAIL reverse_setup got lane %0d exp 5", lane_a); end
      checks++;
      for (int t = 0; t < 3; t++) begin
         sel = sel_tab[t]; tick = 1'b1; step(); tick = 1'b0;
         if (bus_a !== want_tab[t] || vec_a !== exp_a()) begin
            errors++; $display("FAIL reverse tick %0d got bus %h exp %h", t + 1, bus_a, want_tab[t]);
         end
         checks++;
         step();
      end
   endtask

   task automatic test_crash();
      logic [7:0] want;
      idle_inputs();
      sel = 2'b00; tick = 1'b1; step();
      sel = 2'b01; step();
      tick = 1'b0; step();
      if (lane_a !== 3'd6) begin errors++; $display("FAIL crash_setup got lane %0d exp 6", lane_a); end
      checks++;
      tick = 1'b1; crash = 1'b1; step();
      tick = 1'b0; crash = 1'b0;
      if (lane_a !== 3'd6 || st_a !== 2'b10 || cr_a !== 1'b1 || bus_a !== 8'h00) begin
         errors++; $display("FAIL crash_entry got lane %0d st %b cr %b bus %h exp 6 10 1 00", lane_a, st_a, cr_a, bus_a);
      end
      checks++;
      for (int t = 1; t <= 8; t++) begin
         sel = 2'($urandom); crash = 1'($urandom);
         tick = 1'b1; step(); tick = 1'b0; crash = 1'b0;
         want = (t == 8) ? 8'h10 : (t % 2 == 1) ? 8'h40 : 8'h00;
         if (bus_a !== want || vec_a !== exp_a()) begin
            errors++; $display("FAIL crash_blink tick %0d got bus %h vec %h exp bus %h", t, bus_a, vec_a, want);
         end
         checks++;
         step();
      end
      if (st_a !== 2'b01 || cr_a !== 1'b0) begin
         errors++; $display("FAIL crash_respawn got st %b cr %b exp 01 0", st_a, cr_a);
      end
      checks++;
   endtask

   task automatic test_crash_abort();
      idle_inputs();
      crash = 1'b1; step(); crash = 1'b0;
      for (int t = 0; t < 3; t++) begin tick = 1'b1; step(); tick = 1'b0; step(); end
      spawn_n = 1'b0; step(); spawn_n = 1'b1;
      if (st_a !== 2'b01 || bus_a !== 8'h10 || vec_b !== exp_b()) begin
         errors++; $display("FAIL crash_spawn got st %b bus %h exp st 01 bus 10", st_a, bus_a);
      end
      checks++;
      crash = 1'b1; step(); crash = 1'b0;
      tick = 1'b1; step(); step(); tick = 1'b0;
      rst = 1'b1; step(); rst = 1'b0;
      if (vec_a !== 16'h0000 || vec_b !== 25'h0) begin
         errors++; $display("FAIL crash_reset got a %h b %h exp 0", vec_a, vec_b);
      end
      checks++;
   endtask

   task automatic test_wide();
      logic [15:0] want;
      idle_inputs();
      spawn_n = 1'b0; step(); spawn_n = 1'b1;
      sel = 2'b10;
      for (int t = 1; t <= 9; t++) begin
         tick = 1'b1; step(); tick = 1'b0;
         want = 16'h0100 >> ((t > 6) ? 6 : t);
         if (bus_b !== want || vec_b !== exp_b()) begin
            errors++; $display("FAIL wide_right tick %0d got bus %h exp %h", t, bus_b, want);
         end
         checks++;
      end
      if (atr_b !== 1'b1) begin errors++; $display("FAIL wide_atright got %b exp 1", atr_b); end
      checks++;
   endtask

   task automatic test_random();
      idle_inputs();
      spawn_n = 1'b0; step();
      for (int c = 0; c < 3000; c++) begin
         rst     = ($urandom_range(0, 299) == 0);
         spawn_n = !($urandom_range(0, 59) == 0);
         crash   = ($urandom_range(0, 39) == 0);
         tick    = ($urandom_range(0, 2) == 0);
         sel     = ($urandom_range(0, 3) == 0) ? 2'($urandom) : sel;
         step();
         if (vec_a !== exp_a()) begin errors++; $display("FAIL random_a cyc %0d got %h exp %h", c, vec_a, exp_a()); end
         checks++;
         if (vec_b !== exp_b()) begin errors++; $display("FAIL random_b cyc %0d got %h exp %h", c, vec_b, exp_b()); end
         checks++;
      end
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      #2;
      test_reset();
      test_spawn();
      test_hold_left();
      test_reverse();
      test_crash();
      test_crash_abort();
      test_wide();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sc_regshifter_player_lane.md
Name: sc_regshifter_player_lane

Overview:
Parametrised player-position register for the lane-based driving game. It generalises the one-hot lane shifter with the following additions:
- configurable width and lane bounds
- a spawn lane
- tick-gated movement with hold-to-repeat
- a crash/respawn state machine with a blinking output

It sits between the joystick/button decoder and the playfield collision and render logic. Its one-hot output is the player's column on the current playfield row.

Parameters:
DATAWIDTH, 8, width of the one-hot position bus (number of columns)
LANE_MIN, 4, lowest legal bit index (right bound)
LANE_MAX, 7, highest legal bit index (left bound); LANE_MIN <= SPAWN_LANE <= LANE_MAX < DATAWIDTH
SPAWN_LANE, 4, bit index loaded on spawn and on respawn after crash
REPEAT_TICKS, 4, ticks between auto-repeat moves while a direction is held (>= 1)
CRASH_TICKS, 8, ticks spent in CRASH before respawn (>= 1)

Ports:
SC_PlayerLane_CLOCK_50  in  1  system clock
SC_PlayerLane_RESET_InHigh  in  1  synchronous active-high reset
SC_PlayerLane_tick_In  in  1  one-cycle game-tick enable
SC_PlayerLane_spawn_InLow  in  1  active-low spawn/load request
SC_PlayerLane_shiftselection_In  in  2  01 = left (toward MSB), 10 = right (toward LSB), 00/11 = hold
SC_PlayerLane_crash_In  in  1  collision pulse from playfield logic
SC_PlayerLane_data_OutBUS  out  DATAWIDTH  one-hot position, gated by blink
SC_PlayerLane_lane_Out  out  clog2(DATAWIDTH)  binary lane index
SC_PlayerLane_state_Out  out  2  current FSM state
SC_PlayerLane_atLeft_Out  out  1  lane == LANE_MAX and state ACTIVE
SC_PlayerLane_atRight_Out  out  1  lane == LANE_MIN and state ACTIVE
SC_PlayerLane_crash_Out  out  1  high while in CRASH

Behaviour:
- Clocking: one clock; reset is synchronous and active-high. All state updates happen on the rising edge of CLOCK_50.
- Reset: state IDLE, lane 0, repeat counter 0, crash counter 0, last_sel 00, blink 0. All outputs read 0.
- Internal storage: binary lane index. data_OutBUS = (1 << lane) when (ACTIVE) or (CRASH and blink=1); otherwise 0. In IDLE the bus is 0.
- Priority per cycle: reset > spawn > crash > tick-move.
- Spawn (spawn_InLow = 0, level-sampled every cycle, in any state):
  - next state ACTIVE, lane = SPAWN_LANE
  - repeat counter 0, last_sel 00, crash counter 0
  - spawn is not tick-gated
- IDLE: ignores tick, shiftselection and crash.
- ACTIVE, movement (only on tick_In = 1):
  - Direction sel = 01 or 10:
    - If sel != last_sel, move and set repeat counter to 0.
    - Else if repeat counter == REPEAT_TICKS-1, move and set counter to 0.
    - Else increment the counter.
  - Move = lane+1 for 01, lane-1 for 10, saturating at LANE_MAX / LANE_MIN. A blocked move still clears the counter.
  - sel = 00 or 11: no move, counter cleared.
  - last_sel <= sel on every tick.
  - Net effect: while a direction is held, moves occur on ticks 1, 1+R, 1+2R, ... where R = REPEAT_TICKS.
- ACTIVE, crash: crash_In = 1 on any cycle (not tick-gated) gives next state CRASH, crash counter 0, blink 0. Crash wins over a same-cycle tick-move; the lane is frozen at its pre-move value.
- CRASH:
  - Lane is frozen; shiftselection and further crash_In are ignored.
  - On each tick, blink toggles and the crash counter increments.
  - On the tick where the counter == CRASH_TICKS-1: state ACTIVE, lane = SPAWN_LANE, blink 0, last_sel 00, repeat counter 0.
- Reset asserted mid-CRASH or mid-repeat returns everything to the reset values on the next edge. Spawn mid-CRASH aborts the crash immediately.
- Counters are clog2 of their limit plus 1 bit wide and never wrap (they are always cleared at the limit).

Decomposition:
- Package sc_player_pkg holds:
  - state encoding: IDLE = 2'b00, ACTIVE = 2'b01, CRASH = 2'b10
  - shiftselection codes: SEL_HOLD = 2'b00, SEL_LEFT = 2'b01, SEL_RIGHT = 2'b10
- One sub-module, sc_player_repeat_gen: holds last_sel and the repeat counter. It takes tick, sel, clear and outputs a move strobe plus direction. All other logic (FSM, lane register, crash counter, output decode) stays in the top module.

Test Plan:
- Reset, then spawn_InLow = 0 for 1 cycle -> state 01, lane 4, bus 8'h10, atRight 1; before spawn, bus 8'h00 and state 00 regardless of ticks.
- ACTIVE lane 4, hold sel = 01 for 13 ticks -> moves on ticks 1, 5, 9: bus 8'h20, 8'h40, 8'h80. Tick 13 is blocked: bus stays 8'h80, atLeft 1.
- ACTIVE lane 5, hold sel = 10 for 2 ticks, then 01 on tick 3 -> tick 1 gives lane 4; tick 2 blocked, lane 4; tick 3 is a new direction and moves immediately, lane 5, bus 8'h20.
- ACTIVE lane 6, crash_In pulse in the same cycle as a left tick -> lane stays 6, state 10, crash_Out 1, bus 8'h00. Ticks 1..7 alternate bus 8'h40 / 8'h00. Tick 8 gives state 01, bus 8'h10, crash_Out 0.
- In CRASH after 3 ticks, assert spawn_InLow = 0 -> next cycle state 01, bus 8'h10. Assert RESET_InHigh during CRASH instead -> next edge state 00, all outputs 0.
- Parameter set DATAWIDTH = 16, LANE_MIN = 2, LANE_MAX = 13, SPAWN_LANE = 8, REPEAT_TICKS = 1 -> spawn gives bus 16'h0100. Holding right moves every tick down to 16'h0004, then saturates with atRight 1.
